fpu_ret_collect: RTL and testbench
==================================

FPU_RET_COLLECT -- requirements
Module: fpu_ret_collect

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning queue entries; power of two, >= 8.
REQ-002 SHALL have parameter NPORT, default 6, meaning number of return ports; fixed at 6.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports u1_ret..u6_ret, input, 14 bits each: return words from the FPU pair. Bits [4:0] are the IEEE flags NV, DZ, OF, UF, NX. Bits [13:5] are an opaque tag.
REQ-006 SHALL have ports u1_ret_en..u6_ret_en, input, 1 bit each: the matching return word is valid this cycle.
REQ-007 SHALL have port deq_cnt, input, 2 bits: number of head entries the retire stage consumes this cycle (0..2).
REQ-008 SHALL have ports out0_ret and out1_ret, output, 14 bits each: the head entry and head+1 entry.
REQ-009 SHALL have ports out0_en and out1_en, output, 1 bit each: out0 / out1 hold valid entries.
REQ-010 SHALL have port stall, output, 1 bit: upstream must not issue.
REQ-011 SHALL have port ovf, output, 1 bit: sticky overflow indication.
REQ-012 SHALL have port fflags_clr, input, 1 bit: clear the sticky flags.
REQ-013 SHALL have port fflags, output, 5 bits: sticky IEEE flags.

Function
REQ-014 SHALL compact valid inputs each cycle in port order u1..u6 and write them to consecutive entries starting at wr_ptr.
REQ-015 SHALL advance wr_ptr by popcount(ret_en), modulo DEPTH, with wrap-around.
REQ-016 SHALL make an entry written in cycle N visible on out0/out1 no earlier than cycle N+1; there is no same-cycle bypass.
REQ-017 SHALL drive out0 and out1 combinationally from rd_ptr and rd_ptr+1 (mod DEPTH). out0_en = (count>=1); out1_en = (count>=2). Invalid outputs SHALL read 0.
REQ-018 SHALL clamp the effective dequeue to min(deq_cnt, count) and advance rd_ptr by that amount.
REQ-019 SHALL update count as count + enq - deq_eff when enqueue and dequeue occur in the same cycle.
REQ-020 SHALL register stall: it is 1 in cycle N+1 iff free entries after the cycle-N update are < 6.
REQ-021 SHALL write only the first `free` compacted words when the inputs exceed free entries (overflow). It SHALL drop the excess, set ovf, and leave ovf set until reset.
REQ-022 SHALL keep count within 0..DEPTH at all times.

Reset
REQ-023 SHALL, while rst is high, clear wr_ptr, rd_ptr, count, stall, ovf and fflags to 0. It SHALL hold out0_en and out1_en at 0, and entry contents SHALL be don't-care.
REQ-024 SHALL discard in-flight inputs when rst is asserted mid-operation; there is no partial drain.

Configuration
REQ-025 SHALL, with FPU_RETQ_STICKY_EN defined, OR bits [4:0] of every accepted (enqueued) word into fflags at enqueue. Dropped words SHALL NOT contribute.
REQ-026 SHALL give fflags_clr priority over the same-cycle OR, so fflags becomes 0.
REQ-027 SHALL, without FPU_RETQ_STICKY_EN, tie fflags to 0, ignore fflags_clr and instantiate no flag register.

Structure
REQ-028 SHALL place the ret-word field constants (flag bit positions, tag range) and the parameter DEPTH in the shared FPU package.
REQ-029 SHALL place the 6-input compaction (prefix-count and select) in one sub-module, fpu_ret_compact6.

Verification
REQ-030 SHALL cover: after reset, u1/u3/u6 valid with tags 1/3/6 -> next cycle out0 = tag1, out1 = tag3, count = 3.
REQ-031 SHALL cover: all 6 ports valid for 2 cycles, deq_cnt = 0 -> count = 12, stall = 1 in the following cycle.
REQ-032 SHALL cover: count = 14, 6 valid inputs -> 2 written, 4 dropped, ovf = 1, count = 16.
REQ-033 SHALL cover: wr_ptr = 14, 4 inputs -> entries 14, 15, 0, 1 written; readback is in order across the wrap.
REQ-034 SHALL cover: count = 1, deq_cnt = 2 -> deq_eff = 1, count = 0, out0_en = 0.
REQ-035 SHALL cover: with FPU_RETQ_STICKY_EN defined, u2 flags 5'b00001 and u4 flags 5'b10000 in one cycle -> fflags = 5'b10001; fflags_clr the next cycle -> 0.

Source files
------------

// File: rtl/fpu_ret_collect_pkg.sv
// Shared FPU return-queue definitions: return-word layout, default queue
// depth and port count, plus a flag-field extraction helper.
package fpu_ret_collect_pkg;

    localparam int RET_W      = 14;
    localparam int FLAGS_LSB  = 0;
    localparam int FLAGS_MSB  = 4;
    localparam int TAG_LSB    = 5;
    localparam int TAG_MSB    = 13;

    // IEEE flag bit positions inside the flag field.
    localparam int FLAG_NX    = 0;
    localparam int FLAG_UF    = 1;
    localparam int FLAG_OF    = 2;
    localparam int FLAG_DZ    = 3;
    localparam int FLAG_NV    = 4;

    localparam int RETQ_DEPTH = 16;
    localparam int RETQ_NPORT = 6;

    typedef logic [RET_W-1:0]             ret_word_t;
    typedef logic [FLAGS_MSB:FLAGS_LSB]   ret_flags_t;
    typedef logic [TAG_MSB:TAG_LSB]       ret_tag_t;

    function automatic ret_flags_t ret_flags(input ret_word_t w);
        return w[FLAGS_MSB:FLAGS_LSB];
    endfunction

endpackage

// File: rtl/fpu_ret_collect_if.sv
// Bus between the FPU return ports / retire stage and the return collector.
// master = producer/retire side, slave = the collector.
interface fpu_ret_collect_if;
    import fpu_ret_collect_pkg::*;

    ret_word_t  u1_ret, u2_ret, u3_ret, u4_ret, u5_ret, u6_ret;
    logic       u1_ret_en, u2_ret_en, u3_ret_en, u4_ret_en, u5_ret_en, u6_ret_en;
    logic [1:0] deq_cnt;
    logic       fflags_clr;
    ret_word_t  out0_ret, out1_ret;
    logic       out0_en, out1_en;
    logic       stall;
    logic       ovf;
    ret_flags_t fflags;

    modport master (
        output u1_ret, u2_ret, u3_ret, u4_ret, u5_ret, u6_ret,
        output u1_ret_en, u2_ret_en, u3_ret_en, u4_ret_en, u5_ret_en, u6_ret_en,
        output deq_cnt, fflags_clr,
        input  out0_ret, out1_ret, out0_en, out1_en, stall, ovf, fflags
    );

    modport slave (
        input  u1_ret, u2_ret, u3_ret, u4_ret, u5_ret, u6_ret,
        input  u1_ret_en, u2_ret_en, u3_ret_en, u4_ret_en, u5_ret_en, u6_ret_en,
        input  deq_cnt, fflags_clr,
        output out0_ret, out1_ret, out0_en, out1_en, stall, ovf, fflags
    );

endinterface

// File: rtl/fpu_ret_compact6.sv
// Six-input compaction: packs the valid words into slots 0..n-1 in port
// order, limits acceptance to i_limit words and ORs the flags of only the
// accepted words.
module fpu_ret_compact6
    import fpu_ret_collect_pkg::*;
(
    input  ret_word_t [5:0] i_words,
    input  logic [5:0]      i_en,
    input  logic [2:0]      i_limit,
    output ret_word_t [5:0] o_words,
    output logic [2:0]      o_acc,
    output logic            o_drop,
    output ret_flags_t      o_flags
);

    logic [2:0] w_pre [6];
    logic [2:0] w_total;

    // Prefix count: slot index of each valid input among the valid ones.
    always_comb begin
        w_total = 3'd0;
        for (int i = 0; i < 6; i++) begin
            w_pre[i] = w_total;
            w_total  = w_total + {2'd0, i_en[i]};
        end
    end

    // AND-OR select into compacted slots; flags only from accepted words.
    always_comb begin
        o_words = '0;
        o_flags = '0;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 6; i++) begin
                o_words[k] = o_words[k]
                           | ({RET_W{i_en[i] && (w_pre[i] == 3'(k))}} & i_words[i]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            o_flags = o_flags
                    | ({5{i_en[i] && (w_pre[i] < i_limit)}} & ret_flags(i_words[i]));
        end
    end

    assign o_acc  = (w_total < i_limit) ? w_total : i_limit;
    assign o_drop = (w_total > i_limit);

endmodule

// File: rtl/fpu_ret_collect.sv
// FPU return-word collector: a circular queue fed by up to six return ports
// per cycle and drained two-wide by the retire stage.
// Optional feature macro: FPU_RETQ_STICKY_EN (sticky IEEE flag accumulator).
module fpu_ret_collect
    import fpu_ret_collect_pkg::*;
#(
    parameter int DEPTH = RETQ_DEPTH,
    parameter int NPORT = RETQ_NPORT
) (
    input  logic               clk,
    input  logic               rst,
    fpu_ret_collect_if.slave   bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ret_word_t        r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_stall;
    logic             r_ovf;

    ret_word_t [5:0]  w_words;
    logic [5:0]       w_en;
    ret_word_t [5:0]  w_cwords;
    logic [2:0]       w_acc;
    logic             w_drop;
    ret_flags_t       w_acc_flags;
    logic [CW-1:0]    w_free;
    logic [2:0]       w_limit;
    logic [1:0]       w_deq_eff;
    logic [CW-1:0]    w_count_nxt;
    logic [CW-1:0]    w_free_nxt;
    logic [PW-1:0]    w_wr_idx [6];
    logic [PW-1:0]    w_rd1;

    assign w_words = {bus.u6_ret, bus.u5_ret, bus.u4_ret, bus.u3_ret, bus.u2_ret, bus.u1_ret};
    assign w_en    = {bus.u6_ret_en, bus.u5_ret_en, bus.u4_ret_en,
                      bus.u3_ret_en, bus.u2_ret_en, bus.u1_ret_en};

    // Free space is taken before this cycle's dequeue, so entries being
    // retired this cycle are never overwritten by the same-cycle enqueue.
    assign w_free  = CW'(DEPTH) - r_count;
    assign w_limit = (w_free >= CW'(NPORT)) ? 3'(NPORT) : w_free[2:0];

    fpu_ret_compact6 u_compact (
        .i_words (w_words),
        .i_en    (w_en),
        .i_limit (w_limit),
        .o_words (w_cwords),
        .o_acc   (w_acc),
        .o_drop  (w_drop),
        .o_flags (w_acc_flags)
    );

    // Dequeue is clamped to what the queue actually holds.
    always_comb begin
        if (CW'(bus.deq_cnt) <= r_count) begin
            w_deq_eff = bus.deq_cnt;
        end else begin
            w_deq_eff = r_count[1:0];
        end
    end

    assign w_count_nxt = r_count + CW'(w_acc) - CW'(w_deq_eff);
    assign w_free_nxt  = CW'(DEPTH) - w_count_nxt;

    // Write addresses for the compacted slots, wrapping modulo DEPTH.
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            w_wr_idx[k] = r_wr_ptr + PW'(k);
        end
    end

    // Queue storage: no reset, contents only meaningful below count.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 6; k++) begin
            if (3'(k) < w_acc) begin
                r_mem[w_wr_idx[k]] <= w_cwords[k];
            end
        end
    end

    // Pointers, occupancy, registered stall and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_stall  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_acc);
            r_rd_ptr <= r_rd_ptr + PW'(w_deq_eff);
            r_count  <= w_count_nxt;
            r_stall  <= (w_free_nxt < CW'(NPORT));
            r_ovf    <= r_ovf | w_drop;
        end
    end

    assign w_rd1        = r_rd_ptr + PW'(1);
    assign bus.out0_en  = (r_count != '0);
    assign bus.out1_en  = (r_count >= CW'(2));
    assign bus.out0_ret = bus.out0_en ? r_mem[r_rd_ptr] : '0;
    assign bus.out1_ret = bus.out1_en ? r_mem[w_rd1]    : '0;
    assign bus.stall    = r_stall;
    assign bus.ovf      = r_ovf;

`ifdef FPU_RETQ_STICKY_EN
    ret_flags_t r_fflags;

    // Sticky flags: clear wins over the accumulation of accepted words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fflags <= '0;
        end else if (bus.fflags_clr) begin
            r_fflags <= '0;
        end else begin
            r_fflags <= r_fflags | w_acc_flags;
        end
    end

    assign bus.fflags = r_fflags;
`else
    logic w_unused;
    assign w_unused   = ^{w_acc_flags, bus.fflags_clr};
    assign bus.fflags = 5'd0;
`endif

endmodule

// File: tb/tb_fpu_ret_collect.sv
// Self-checking bench for fpu_ret_collect: directed scenarios followed by
// randomized traffic, compared against a queue-based reference model.
module tb_fpu_ret_collect;
    import fpu_ret_collect_pkg::*;

    localparam int D = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpu_ret_collect_if ifc();

    fpu_ret_collect #(.DEPTH(D), .NPORT(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int tests = 0;
    int fails = 0;

    ret_word_t  mq[$];
    logic       m_ovf;
    logic       m_stall;
    logic [4:0] m_ff;

    function automatic ret_word_t mk(input int tag, input logic [4:0] fl);
        return {9'(tag), fl};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [31:0] e0, e1;
        e0 = (mq.size() >= 1) ? 32'(mq[0]) : 32'd0;
        e1 = (mq.size() >= 2) ? 32'(mq[1]) : 32'd0;
        chk({tag, ".out0_en"},  32'(ifc.out0_en),  32'(mq.size() >= 1));
        chk({tag, ".out1_en"},  32'(ifc.out1_en),  32'(mq.size() >= 2));
        chk({tag, ".out0_ret"}, 32'(ifc.out0_ret), e0);
        chk({tag, ".out1_ret"}, 32'(ifc.out1_ret), e1);
        chk({tag, ".stall"},    32'(ifc.stall),    32'(m_stall));
        chk({tag, ".ovf"},      32'(ifc.ovf),      32'(m_ovf));
        chk({tag, ".fflags"},   32'(ifc.fflags),   32'(m_ff));
    endtask

    task automatic set_in(input logic [5:0] en, input logic [5:0][13:0] w,
                          input logic [1:0] deq, input logic clr);
        ifc.u1_ret = w[0]; ifc.u2_ret = w[1]; ifc.u3_ret = w[2];
        ifc.u4_ret = w[3]; ifc.u5_ret = w[4]; ifc.u6_ret = w[5];
        ifc.u1_ret_en = en[0]; ifc.u2_ret_en = en[1]; ifc.u3_ret_en = en[2];
        ifc.u4_ret_en = en[3]; ifc.u5_ret_en = en[4]; ifc.u6_ret_en = en[5];
        ifc.deq_cnt    = deq;
        ifc.fflags_clr = clr;
    endtask

    // Reference: accept up to the free space seen at cycle start, in port
    // order; drop the rest; retire min(deq, occupancy) from the front.
    task automatic model_step(input logic [5:0] en, input logic [5:0][13:0] w,
                              input logic [1:0] deq, input logic clr);
        int free, de;
        ret_word_t acc[$];
        logic [4:0] fo;
        free = D - mq.size();
        de   = (int'(deq) < mq.size()) ? int'(deq) : mq.size();
        fo   = 5'd0;
        for (int i = 0; i < 6; i++) begin
            if (en[i]) begin
                if (acc.size() < free) begin
                    acc.push_back(w[i]);
                    fo = fo | w[i][4:0];
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        for (int i = 0; i < de; i++) void'(mq.pop_front());
        foreach (acc[i]) mq.push_back(acc[i]);
`ifdef FPU_RETQ_STICKY_EN
        if (clr) m_ff = 5'd0;
        else     m_ff = m_ff | fo;
`endif
        m_stall = ((D - mq.size()) < 6);
    endtask

    task automatic cyc(input logic [5:0] en, input logic [5:0][13:0] w,
                       input logic [1:0] deq, input logic clr, input string tag);
        set_in(en, w, deq, clr);
        @(posedge clk);
        model_step(en, w, deq, clr);
        @(negedge clk);
        chk_model(tag);
    endtask

    task automatic model_clear();
        mq.delete();
        m_ovf   = 1'b0;
        m_stall = 1'b0;
        m_ff    = 5'd0;
    endtask

    logic [5:0][13:0] w;
    logic [5:0]       ren;

    initial begin
        model_clear();
        w = '0;
        set_in(6'd0, w, 2'd0, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        chk_model("reset");
        rst = 1'b0;

        // Three sparse ports land in order
        w = '0;
        w[0] = mk(1, 5'd0); w[2] = mk(3, 5'd0); w[5] = mk(6, 5'd0);
        w[1] = mk(99, 5'd7);
        cyc(6'b100101, w, 2'd0, 1'b0, "sparse3");
        chk("sparse3.out0_tag1", 32'(ifc.out0_ret), 32'(mk(1, 5'd0)));
        chk("sparse3.out1_tag3", 32'(ifc.out1_ret), 32'(mk(3, 5'd0)));
        cyc(6'd0, w, 2'd2, 1'b0, "deq2_of3");
        chk("deq2_of3.out0_tag6", 32'(ifc.out0_ret), 32'(mk(6, 5'd0)));
        // Dequeue request larger than occupancy
        cyc(6'd0, w, 2'd2, 1'b0, "deq_clamp");
        chk("deq_clamp.out0_en", 32'(ifc.out0_en), 32'd0);

        // Two full-width cycles: 12 entries, stall asserted
        for (int i = 0; i < 6; i++) w[i] = mk(10 + i, 5'd0);
        cyc(6'h3f, w, 2'd0, 1'b0, "fill6");
        chk("fill6.stall", 32'(ifc.stall), 32'd0);
        for (int i = 0; i < 6; i++) w[i] = mk(20 + i, 5'd0);
        cyc(6'h3f, w, 2'd0, 1'b0, "fill12");
        chk("fill12.stall", 32'(ifc.stall), 32'd1);

        // Overflow: 14 held, 6 offered, 2 accepted
        w[0] = mk(30, 5'd0); w[1] = mk(31, 5'd0);
        cyc(6'b000011, w, 2'd0, 1'b0, "fill14");
        chk("fill14.ovf", 32'(ifc.ovf), 32'd0);
        for (int i = 0; i < 6; i++) w[i] = mk(40 + i, 5'd0);
        cyc(6'h3f, w, 2'd0, 1'b0, "ovf");
        chk("ovf.ovf", 32'(ifc.ovf), 32'd1);
        for (int i = 0; i < 7; i++) cyc(6'd0, w, 2'd2, 1'b0, "drain_full");
        chk("drain_full.last_out0", 32'(ifc.out0_ret), 32'(mk(40, 5'd0)));
        chk("drain_full.last_out1", 32'(ifc.out1_ret), 32'(mk(41, 5'd0)));
        cyc(6'd0, w, 2'd2, 1'b0, "drain_empty");
        chk("drain_empty.ovf_sticky", 32'(ifc.ovf), 32'd1);

        // Reset asserted with traffic in flight
        for (int i = 0; i < 6; i++) w[i] = mk(60 + i, 5'b11111);
        set_in(6'h3f, w, 2'd1, 1'b0);
        rst = 1'b1;
        #1;
        model_clear();
        chk_model("midrst_async");
        @(posedge clk);
        @(negedge clk);
        chk_model("midrst_held");
        rst = 1'b0;
        set_in(6'd0, w, 2'd0, 1'b0);

        // Move pointers to 14, then write across the wrap
        for (int i = 0; i < 6; i++) w[i] = mk(70 + i, 5'd0);
        cyc(6'h3f, w, 2'd0, 1'b0, "adv6");
        cyc(6'h3f, w, 2'd0, 1'b0, "adv12");
        cyc(6'b000011, w, 2'd0, 1'b0, "adv14");
        for (int i = 0; i < 7; i++) cyc(6'd0, w, 2'd2, 1'b0, "adv_drain");
        for (int i = 0; i < 4; i++) w[i] = mk(50 + i, 5'd0);
        cyc(6'b001111, w, 2'd0, 1'b0, "wrap_wr");
        chk("wrap_wr.out0", 32'(ifc.out0_ret), 32'(mk(50, 5'd0)));
        chk("wrap_wr.out1", 32'(ifc.out1_ret), 32'(mk(51, 5'd0)));
        cyc(6'd0, w, 2'd2, 1'b0, "wrap_rd");
        chk("wrap_rd.out0", 32'(ifc.out0_ret), 32'(mk(52, 5'd0)));
        chk("wrap_rd.out1", 32'(ifc.out1_ret), 32'(mk(53, 5'd0)));
        cyc(6'd0, w, 2'd2, 1'b0, "wrap_empty");

        // Sticky flags and clear
        w = '0;
        w[1] = mk(2, 5'b00001); w[3] = mk(4, 5'b10000); w[0] = mk(9, 5'b01110);
        cyc(6'b001010, w, 2'd0, 1'b0, "flags_or");
`ifdef FPU_RETQ_STICKY_EN
        chk("flags_or.fflags", 32'(ifc.fflags), 32'b10001);
`else
        chk("flags_or.fflags", 32'(ifc.fflags), 32'd0);
`endif
        cyc(6'd0, w, 2'd2, 1'b1, "flags_clr");
        chk("flags_clr.fflags", 32'(ifc.fflags), 32'd0);

        // Randomized traffic, alternating fill-heavy and drain-heavy phases
        for (int n = 0; n < 400; n++) begin
            logic [1:0] dq;
            for (int i = 0; i < 6; i++) w[i] = 14'($urandom);
            if (((n / 50) % 2) == 0) begin
                ren = 6'($urandom);
                dq  = 2'($urandom_range(0, 2));
            end else begin
                ren = 6'($urandom & $urandom & $urandom);
                dq  = 2'd2;
            end
            cyc(ren, w, dq, ($urandom_range(0, 15) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
